// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the pipe_MIPS32 debug/readback blocks.
package mips_dbg_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 11;

  // Data memory read port returns data this many cycles after the strobe.
  localparam int MEM_RD_LAT = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_REQ   = 3'd2,
    ST_RESP  = 3'd3,
    ST_OUT   = 3'd4,
    ST_FIN   = 3'd5
  } dump_state_e;

endpackage

// File: rtl/halt_mem_dump_if.sv
// Valid/ready stream carrying one dumped memory word and its address.
interface halt_mem_dump_if
  import mips_dbg_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              last;

  modport master (output valid, output data, output addr, output last, input ready);
  modport slave  (input valid, input data, input addr, input last, output ready);

endinterface

// File: rtl/halt_mem_dump_rise_detect.sv
// Registered 1-bit rising-edge detector.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Remember the previous-cycle level of d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/halt_mem_dump.sv
// Post-run data-memory dump engine: waits for HALTED to rise, then streams
// a window of memory words out over a valid/ready interface.
module halt_mem_dump
  import mips_dbg_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic                arm,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [CNT_W-1:0]    word_count,
  input  logic                halted,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rd_data,
  halt_mem_dump_if.master     out,
  output logic                busy,
  output logic                done
);

  localparam logic [2:0] IDLE  = 3'(ST_IDLE);
  localparam logic [2:0] ARMED = 3'(ST_ARMED);
  localparam logic [2:0] REQ   = 3'(ST_REQ);
  localparam logic [2:0] RESP  = 3'(ST_RESP);
  localparam logic [2:0] OUT   = 3'(ST_OUT);
  localparam logic [2:0] FIN   = 3'(ST_FIN);

  logic [2:0]        state;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  remain;
  logic              halted_rise;

  // The edge register samples halted every cycle, so the level seen on the
  // arm cycle is already the reference: a halted that is high at arm time
  // cannot produce a rise until it has dropped and risen again.
  rise_detect u_halted_rise (
    .clk   (clk1),
    .rst_n (rst_n),
    .d     (halted),
    .rise  (halted_rise)
  );

  // Dump sequencer: one read, one capture, one output beat per word.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_addr <= '0;
      remain   <= '0;
      out.data <= '0;
      out.addr <= '0;
      out.last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            cur_addr <= start_addr;
            remain   <= word_count;
            state    <= ARMED;
          end
        end
        ARMED: begin
          if (halted_rise) state <= (remain == '0) ? FIN : REQ;
        end
        REQ: begin
          state <= RESP;
        end
        RESP: begin
          out.data <= mem_rd_data;
          out.addr <= cur_addr;
          out.last <= (remain == CNT_W'(1));
          state    <= OUT;
        end
        OUT: begin
          if (out.ready) begin
            remain   <= remain - CNT_W'(1);
            cur_addr <= cur_addr + ADDR_W'(1);
            state    <= (remain == CNT_W'(1)) ? FIN : REQ;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Decoded outputs; address is forced to zero whenever no read is issued.
  assign mem_rd_en = (state == REQ);
  assign mem_addr  = (state == REQ) ? cur_addr : '0;
  assign out.valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

endmodule

// File: tb/tb_halt_mem_dump.sv
// Scoreboard bench for halt_mem_dump: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_halt_mem_dump;

  typedef struct packed {
    logic [31:0] data;
    logic [9:0]  addr;
    logic        last;
  } beat_t;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic [9:0]  start_addr = '0;
  logic [10:0] word_count = '0;
  logic        halted = 1'b0;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rd_data = '0;
  logic        busy;
  logic        done;
  logic        out_ready = 1'b1;

  logic [31:0] mem [0:1023];

  halt_mem_dump_if #(.ADDR_W(10), .DATA_W(32)) sif ();
  assign sif.ready = out_ready;

  halt_mem_dump #(.ADDR_W(10), .DATA_W(32), .CNT_W(11)) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .arm         (arm),
    .start_addr  (start_addr),
    .word_count  (word_count),
    .halted      (halted),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .out         (sif),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk1 = ~clk1;

  // Synchronous 1-cycle-latency data memory.
  always @(posedge clk1) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q [$];
  int    hs_q [$];
  int    beats = 0, done_cnt = 0, rd_cnt = 0;
  int    first_rd = -1, first_vld = -1, done_cyc = -1, last_hs_cyc = -1;
  int    t0 = 0;
  logic  hold_pend = 1'b0;
  beat_t held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each accepted beat, checks stability
  // under backpressure and tallies done pulses and memory reads.
  always @(negedge clk1) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", sif.valid, 1'b1);
        chk("hold_data", sif.data, held.data);
        chk("hold_addr", sif.addr, held.addr);
        chk("hold_last", sif.last, held.last);
      end
      if (sif.valid && first_vld < 0) first_vld = cyc;
      if (sif.valid && out_ready) begin
        beat_t e;
        beats++;
        hs_q.push_back(cyc);
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {sif.data, sif.addr, sif.last}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", sif.data, e.data);
          chk("beat_addr", sif.addr, e.addr);
          chk("beat_last", sif.last, e.last);
        end
      end
      hold_pend = sif.valid && !out_ready;
      held = '{data: sif.data, addr: sif.addr, last: sif.last};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mem_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        chk("rd_while_valid", sif.valid, 1'b0);
      end
    end
  end

  task automatic do_arm(input logic [9:0] a, input logic [10:0] c);
    @(posedge clk1); #1;
    arm = 1'b1; start_addr = a; word_count = c;
    @(posedge clk1); #1;
    arm = 1'b0;
  endtask

  task automatic raise_halted();
    @(posedge clk1); #1;
    t0 = cyc;
    first_rd = -1;
    first_vld = -1;
    hs_q.delete();
    halted = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk1);
      n++;
    end while (busy && n < budget);
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (beats < target && n < budget) begin
      @(negedge clk1);
      n++;
    end
    chk("beat_timeout", beats >= target, 1'b1);
  endtask

  task automatic drop_halted();
    @(posedge clk1); #1;
    halted = 1'b0;
    @(posedge clk1); #1;
  endtask

  task automatic single_word(input string tag);
    int d0, r0, b0;
    d0 = done_cnt; r0 = rd_cnt; b0 = beats;
    mem[200] = 32'd7;
    do_arm(10'd200, 11'd1);
    exp_q.push_back('{data: 32'd7, addr: 10'd200, last: 1'b1});
    raise_halted();
    wait_idle(40);
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_reads"}, rd_cnt - r0, 1);
    chk({tag, "_beats"}, beats - b0, 1);
    chk({tag, "_done_lat"}, done_cyc, last_hs_cyc + 1);
    chk({tag, "_q_empty"}, exp_q.size(), 0);
    drop_halted();
  endtask

  initial begin
    int d0, r0, b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000 | i;

    // Reset state.
    #12;
    chk("rst_valid", sif.valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_en", mem_rd_en, 1'b0);
    chk("rst_data", sif.data, 32'h0);
    @(posedge clk1); #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk1);

    // Single word.
    single_word("single");

    // Factorial window with latency / spacing checks, a stray arm and a
    // mid-dump halted fall, neither of which may disturb the dump.
    mem[198] = 32'd5040; mem[199] = 32'd0; mem[200] = 32'd7;
    d0 = done_cnt; r0 = rd_cnt; b0 = beats;
    do_arm(10'd198, 11'd3);
    exp_q.push_back('{data: 32'd5040, addr: 10'd198, last: 1'b0});
    exp_q.push_back('{data: 32'd0,    addr: 10'd199, last: 1'b0});
    exp_q.push_back('{data: 32'd7,    addr: 10'd200, last: 1'b1});
    raise_halted();
    do_arm(10'd5, 11'd9);
    wait_beats(b0 + 1, 40);
    halted = 1'b0;
    wait_idle(60);
    chk("fact_rd_lat", first_rd, t0 + 1);
    chk("fact_vld_lat", first_vld, t0 + 3);
    chk("fact_nbeats", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      chk("fact_gap1", hs_q[1] - hs_q[0], 3);
      chk("fact_gap2", hs_q[2] - hs_q[1], 3);
    end
    chk("fact_done", done_cnt - d0, 1);
    chk("fact_reads", rd_cnt - r0, 3);
    chk("fact_q_empty", exp_q.size(), 0);
    drop_halted();

    // Backpressure on the second beat.
    d0 = done_cnt; r0 = rd_cnt; b0 = beats;
    do_arm(10'd198, 11'd3);
    exp_q.push_back('{data: 32'd5040, addr: 10'd198, last: 1'b0});
    exp_q.push_back('{data: 32'd0,    addr: 10'd199, last: 1'b0});
    exp_q.push_back('{data: 32'd7,    addr: 10'd200, last: 1'b1});
    raise_halted();
    wait_beats(b0 + 1, 40);
    @(posedge clk1); #1;
    out_ready = 1'b0;
    repeat (2) @(posedge clk1);
    #1;
    chk("bp_valid_up", sif.valid, 1'b1);
    repeat (5) @(posedge clk1);
    #1;
    out_ready = 1'b1;
    wait_idle(60);
    chk("bp_done", done_cnt - d0, 1);
    chk("bp_reads", rd_cnt - r0, 3);
    chk("bp_beats", beats - b0, 3);
    chk("bp_q_empty", exp_q.size(), 0);
    drop_halted();

    // Zero count.
    d0 = done_cnt; r0 = rd_cnt; b0 = beats;
    do_arm(10'd5, 11'd0);
    chk("zero_busy", busy, 1'b1);
    raise_halted();
    wait_idle(20);
    chk("zero_done", done_cnt - d0, 1);
    chk("zero_reads", rd_cnt - r0, 0);
    chk("zero_beats", beats - b0, 0);
    drop_halted();

    // Halted already high at arm time.
    d0 = done_cnt; r0 = rd_cnt; b0 = beats;
    halted = 1'b1;
    repeat (2) @(posedge clk1);
    do_arm(10'd200, 11'd1);
    exp_q.push_back('{data: 32'd7, addr: 10'd200, last: 1'b1});
    repeat (6) @(posedge clk1);
    #1;
    chk("prehigh_busy", busy, 1'b1);
    chk("prehigh_reads", rd_cnt - r0, 0);
    halted = 1'b0;
    raise_halted();
    wait_idle(40);
    chk("prehigh_done", done_cnt - d0, 1);
    chk("prehigh_beats", beats - b0, 1);
    drop_halted();

    // Address wrap.
    mem[1023] = 32'hDEAD_BEEF; mem[0] = 32'h1234_5678;
    d0 = done_cnt; b0 = beats;
    do_arm(10'd1023, 11'd2);
    exp_q.push_back('{data: 32'hDEAD_BEEF, addr: 10'd1023, last: 1'b0});
    exp_q.push_back('{data: 32'h1234_5678, addr: 10'd0,    last: 1'b1});
    raise_halted();
    wait_idle(40);
    chk("wrap_done", done_cnt - d0, 1);
    chk("wrap_beats", beats - b0, 2);
    chk("wrap_q_empty", exp_q.size(), 0);
    drop_halted();

    // Asynchronous reset while a beat is waiting in OUT.
    d0 = done_cnt; b0 = beats;
    out_ready = 1'b0;
    do_arm(10'd198, 11'd3);
    raise_halted();
    begin
      int n = 0;
      while (!sif.valid && n < 20) begin
        @(negedge clk1);
        n++;
      end
    end
    chk("rstmid_reached_out", sif.valid, 1'b1);
    @(negedge clk1); #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", sif.valid, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_done", done, 1'b0);
    chk("rstmid_data", sif.data, 32'h0);
    chk("rstmid_addr", sif.addr, 10'h0);
    chk("rstmid_rd_en", mem_rd_en, 1'b0);
    halted = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk1);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk1);
    chk("rstmid_no_done", done_cnt - d0, 0);
    chk("rstmid_no_beat", beats - b0, 0);
    single_word("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/halt_mem_dump.md
Name: halt_mem_dump

Overview:
- Post-run memory readback engine for the pipe_MIPS32 verification flow.
- Arms on a host command and waits for the processor HALTED flag to rise.
- After the rise, it reads a configured window of data memory through a synchronous 1-cycle-latency read port.
- Each word is streamed out on a valid/ready interface, so benches and debug hosts never peek into memory hierarchically.

Parameters:
- ADDR_W, 10, memory word-address width
- DATA_W, 32, memory word width
- CNT_W, 11, width of word_count (max ADDR_W+1 bits)

Ports:
- clk1  in  1  single system clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- arm  in  1  one-cycle pulse; latches start_addr/word_count and enters ARMED
- start_addr  in  ADDR_W  first word address to dump
- word_count  in  CNT_W  number of words to dump
- halted  in  1  processor HALTED flag
- mem_rd_en  out  1  read strobe to data memory
- mem_addr  out  ADDR_W  read address
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
- out_valid  out  1  stream word valid
- out_ready  in  1  stream sink ready
- out_data  out  DATA_W  dumped word
- out_addr  out  ADDR_W  address of out_data
- out_last  out  1  high on final beat
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after last beat accepted, or on zero-count completion

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; internal address, remaining count, and halted_q cleared.
- Reset mid-dump aborts immediately. No partial done is generated.
- States: IDLE, ARMED, REQ, RESP, OUT, FIN.
- IDLE -> ARMED on arm=1:
  - Capture start_addr into cur_addr and word_count into remain.
  - Capture halted into halted_q, so a level that is already high does not trigger.
- ARMED -> REQ when halted=1 and halted_q=0 (rising edge). halted_q updates every cycle.
- ARMED -> FIN instead of REQ if remain==0 at the edge.
- REQ (one cycle): mem_rd_en=1, mem_addr=cur_addr. Next state is RESP.
- RESP: register mem_rd_data into out_data and cur_addr into out_addr. Set out_last = (remain==1). Next state is OUT.
- OUT: out_valid=1. out_data, out_addr, and out_last must hold stable until the handshake.
- Handshake fires on out_valid && out_ready in the same cycle:
  - remain decrements; cur_addr increments modulo 2^ADDR_W (wraps from all-ones to 0).
  - If remain was 1 -> FIN; otherwise -> REQ.
- out_valid deasserts the cycle after the handshake.
- Throughput: 3 cycles per word when out_ready is held high.
- FIN (one cycle): done=1, then -> IDLE.
- arm while busy is ignored.
- halted edges outside ARMED are ignored. halted falling mid-dump is ignored.
- mem_rd_en is never asserted outside REQ. At most one read is outstanding.
- Latency: a halted rise at edge N gives mem_rd_en at N+1 and out_valid at N+3.

Decomposition:
- Shared package mips_dbg_pkg holds:
  - state enum (IDLE..FIN)
  - default widths ADDR_W/DATA_W/CNT_W
  - MEM_RD_LAT=1 constant
- Optional sub-module: rise_detect (1-bit registered edge detector, async active-low reset), reused for halted.
- Everything else stays in one module.

Test Plan:
- Single word: arm with start_addr=200, count=1; Mem[200]=7; raise halted -> exactly one beat: out_data=7, out_addr=200, out_last=1; done one cycle after the accept.
- Factorial result window: Mem[198]=5040, Mem[199]=0, Mem[200]=7; arm start 198, count 3; halted rises; out_ready=1 -> beats (198,5040), (199,0), (200,7,last); 3-cycle spacing; done pulses once.
- Backpressure: same as previous with out_ready low for 5 cycles on beat 2 -> out_valid held, data/addr stable, no extra mem_rd_en, no beat lost or duplicated.
- Zero count and pre-high halted:
  - Arm count 0, then raise halted -> no out_valid; done pulses.
  - Arm while halted already 1 -> no dump until halted falls and rises again.
- Wrap: ADDR_W=10, start 1023, count 2 -> beat addresses 1023 then 0.
- Reset mid-dump: assert rst_n=0 asynchronously between clock edges during OUT -> all outputs 0 immediately; no done; after release, the next arm/halted sequence works normally.
